mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit controller in the EX stage of the five-stage MIPS pipeline.
- Accepts one HI/LO operation per issue and holds it for a fixed multi-cycle latency.
- Drives `busy` to the hazard unit, which stalls HI/LO-class instructions while `start || busy`.
- Owns the architectural HI and LO registers and commits results at the end of the latency window.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15.
- DIV_LAT, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage HI/LO op valid this cycle.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, others NONE.
- a  input  32  rs operand.
- b  input  32  rt operand.
- flush  input  1  interrupt/exception flush of the EX instruction; cancels a same-cycle start.
- busy  output  1  registered; operation in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (async, any time including mid-operation):
  - busy=0, hi=0, lo=0, counter=0, state IDLE.
  - Pending result is discarded.
- States: IDLE and RUN.
- Accepted start: `start && !flush && !busy && op != NONE`.
- Accepted MULT/MULTU/DIV/DIVU/MADD/MADDU:
  - Capture the result into pending registers at that clock edge.
  - Load the counter with the op's latency; go to RUN; busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1: commit pending to hi/lo, set busy=0, go to IDLE.
  - busy is high for exactly LAT cycles.
  - hi/lo are updated in the same edge that drops busy.
- hi/lo are unchanged throughout RUN; the new values are first visible in the cycle busy reads 0.
- MTHI/MTLO:
  - Write a into hi (MTHI) or lo (MTLO) at the accepting edge.
  - No busy; state stays IDLE.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit a*b.
  - MULTU: {hi,lo} = unsigned 64-bit a*b.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
  - Divide with b==0: the full DIV_LAT busy window still runs; hi/lo keep their previous values.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; no state change. The hazard unit guarantees this never happens; the bench flags it as a protocol error.
- flush with start in the same cycle: op ignored, including MTHI/MTLO.
- flush during RUN: no effect; the in-flight op, issued by an older committed instruction, completes.
- op=NONE or an undefined code with start: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- With the macro defined:
  - MADD: {hi,lo} = {hi,lo} + signed a*b.
  - MADDU: {hi,lo} = {hi,lo} + unsigned a*b.
  - Both are 64-bit modulo and use MULT_LAT.
  - The accumulator is the hi/lo value at the accepting edge.
- Without the macro: op codes 7 and 8 are treated as NONE (no busy, hi/lo unchanged).

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start 1 cycle:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1; hi/lo unchanged while busy.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero, and MTHI with flush:
  - MTHI 0x1234 (start alone) -> hi=0x1234 next cycle, busy stays 0.
  - DIVU a=7, b=0 -> busy 10 cycles, hi=0x1234 and lo unchanged.
  - MTHI 0xAAAA with flush=1 in the same cycle -> hi stays 0x1234.
- Reset mid-operation: DIV started, reset pulsed on cycle 4 -> busy, hi, lo all 0 immediately (asynchronously); a subsequent MULT 3*4 gives lo=12, hi=0 after 5 cycles.
- With MDU_MADD_EN:
  - hi=0, lo=10, MADD a=2, b=3 -> lo=16 after 5 cycles.
  - MADDU a=0xFFFFFFFF, b=0xFFFFFFFF -> {hi,lo}=0xFFFFFFFE_00000011.
  - Without the macro, the same ops leave hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide controller with a fixed MULT_LAT/DIV_LAT busy window; results commit as busy drops.
// Starts while busy are ignored, as the hazard unit stalls on start||busy. Define MDU_MADD_EN for MADD/MADDU.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif
    localparam logic [3:0] LAT_MUL  = 4'(MULT_LAT);
    localparam logic [3:0] LAT_DIV  = 4'(DIV_LAT);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_b_zero;
    logic [31:0] w_udiv_d;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sdiv_d;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic        w_long;
    logic        w_wr;
    logic [3:0]  w_lat;
    logic [63:0] w_res;

    assign w_accept = i_start && !i_flush && !r_busy;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};

    // Divisor forced to 1 on b==0 so the dividers never see zero; the result is discarded anyway.
    assign w_b_zero = (i_b == 32'd0);
    assign w_udiv_d = w_b_zero ? 32'd1 : i_b;
    assign w_uq     = i_a / w_udiv_d;
    assign w_ur     = i_a % w_udiv_d;

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign w_abs_a  = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_abs_b  = i_b[31] ? (32'd0 - i_b) : i_b;
    assign w_sdiv_d = w_b_zero ? 32'd1 : w_abs_b;
    assign w_sq_mag = w_abs_a / w_sdiv_d;
    assign w_sr_mag = w_abs_a % w_sdiv_d;
    assign w_sq     = (i_a[31] ^ i_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = i_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

`ifdef MDU_MADD_EN
    logic [63:0] w_madd_s;
    logic [63:0] w_madd_u;
    assign w_madd_s = {r_hi, r_lo} + w_prod_s;
    assign w_madd_u = {r_hi, r_lo} + w_prod_u;
`endif

    always_comb begin
        w_long = 1'b0;
        w_wr   = 1'b0;
        w_lat  = 4'd0;
        w_res  = 64'd0;
        case (i_op)
            OP_MULT:  begin w_long = 1'b1; w_wr = 1'b1;      w_lat = LAT_MUL; w_res = w_prod_s;     end
            OP_MULTU: begin w_long = 1'b1; w_wr = 1'b1;      w_lat = LAT_MUL; w_res = w_prod_u;     end
            OP_DIV:   begin w_long = 1'b1; w_wr = !w_b_zero; w_lat = LAT_DIV; w_res = {w_sr, w_sq}; end
            OP_DIVU:  begin w_long = 1'b1; w_wr = !w_b_zero; w_lat = LAT_DIV; w_res = {w_ur, w_uq}; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin w_long = 1'b1; w_wr = 1'b1;      w_lat = LAT_MUL; w_res = w_madd_s;     end
            OP_MADDU: begin w_long = 1'b1; w_wr = 1'b1;      w_lat = LAT_MUL; w_res = w_madd_u;     end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_long) begin
                            r_pend_hi <= w_res[63:32];
                            r_pend_lo <= w_res[31:0];
                            r_pend_wr <= w_wr;
                            r_cnt     <= w_lat;
                            r_busy    <= 1'b1;
                            r_state   <= S_RUN;
                        end else if (i_op == OP_MTHI) begin
                            r_hi <= i_a;
                        end else if (i_op == OP_MTLO) begin
                            r_lo <= i_a;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd1) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected {hi,lo}, busy window length, HI/LO stability.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_a     (a),
        .i_b     (b),
        .i_flush (flush),
        .o_busy  (busy),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // A start reaching the DUT while busy is a hazard-unit protocol violation.
    always @(posedge clk) begin
        if (!reset && start) begin
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL protocol start_while_busy busy=%0b required 0", busy);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; flush = fl;
        @(negedge clk);
        start = 1'b0; op = OP_NONE; flush = 1'b0;
    endtask

    task automatic wait_busy(output int cyc, output bit stable);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi; l0 = lo; cyc = 0; stable = 1'b1;
        while (busy && cyc < 40) begin
            cyc++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_long(input string name, input logic [3:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [63:0] e, input int lat);
        int cyc; bit st; logic [63:0] got;
        exp_q.push_back(e);
        issue(o, x, y, 1'b0);
        wait_busy(cyc, st);
        checks++; if (cyc !== lat) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, cyc, lat); end
        checks++; if (!st) begin errors++; $display("FAIL %s_hilo_stable_while_busy got=changed exp=unchanged", name); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s_scoreboard got=empty exp=entry", name);
        end else begin
            got = exp_q.pop_front();
            if ({hi, lo} !== got) begin errors++; $display("FAIL %s_result got=%h exp=%h", name, {hi, lo}, got); end
            m_hi = got[63:32]; m_lo = got[31:0];
        end
    endtask

    task automatic test_mult;
        test_long("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 5);
        test_long("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5);
    endtask

    task automatic test_div;
        test_long("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
        test_long("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10);
    endtask

    task automatic test_divzero_mthi;
        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got=%h exp=1234", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
        m_hi = 32'h1234;
        test_long("divu_zero", OP_DIVU, 32'd7, 32'd0, {m_hi, m_lo}, 10);
        issue(OP_MTHI, 32'hAAAA, 32'd0, 1'b1);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_flush_hi got=%h exp=1234", hi); end
        issue(OP_MULT, 32'd9, 32'd9, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_flush_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL async_reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL async_reset_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        test_long("mult_after_reset", OP_MULT, 32'd3, 32'd4, 64'd12, 5);
    endtask

    task automatic test_flush_run;
        int cyc; bit st; logic [63:0] got;
        exp_q.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_busy(cyc, st);
        checks++; if (cyc !== 9) begin errors++; $display("FAIL flush_run_busy_rest got=%0d exp=9", cyc); end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL flush_run_scoreboard got=empty exp=entry");
        end else begin
            got = exp_q.pop_front();
            if ({hi, lo} !== got) begin errors++; $display("FAIL flush_run_result got=%h exp=%h", {hi, lo}, got); end
            m_hi = got[63:32]; m_lo = got[31:0];
        end
    endtask

    task automatic test_none;
        logic [3:0] codes [3];
        codes[0] = OP_NONE; codes[1] = 4'd9; codes[2] = 4'd15;
        for (int i = 0; i < 3; i++) begin
            issue(codes[i], 32'hDEAD, 32'hBEEF, 1'b0);
            checks++;
            if (busy !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
                errors++;
                $display("FAIL none_op%0d got busy=%0b hilo=%h exp busy=0 hilo=%h", codes[i], busy, {hi, lo}, {m_hi, m_lo});
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] o; logic [31:0] x; logic [31:0] y; logic [63:0] e;
        int ix; int iy; longint unsigned ux; longint unsigned uy;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(1, 4));
            x = $urandom; y = $urandom | 32'd1;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
            ix = x; iy = y; ux = x; uy = y;
            case (o)
                OP_MULT:  e = 64'(longint'(ix) * longint'(iy));
                OP_MULTU: e = ux * uy;
                OP_DIV:   e = {32'(ix % iy), 32'(ix / iy)};
                default:  e = {x % y, x / y};
            endcase
            test_long("random", o, x, y, e, (o <= OP_MULTU) ? 5 : 10);
        end
    endtask

    task automatic test_madd;
        issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
        issue(OP_MTLO, 32'd10, 32'd0, 1'b0);
        checks++; if ({hi, lo} !== 64'd10) begin errors++; $display("FAIL mtlo_setup got=%h exp=%h", {hi, lo}, 64'd10); end
        m_hi = 32'd0; m_lo = 32'd10;
`ifdef MDU_MADD_EN
        test_long("madd", OP_MADD, 32'd2, 32'd3, 64'd16, 5);
        test_long("maddu", OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000011, 5);
`else
        issue(OP_MADD, 32'd2, 32'd3, 1'b0);
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL madd_disabled got busy=%0b hilo=%h exp busy=0 hilo=%h", busy, {hi, lo}, {m_hi, m_lo});
        end
        issue(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL maddu_disabled got busy=%0b hilo=%h exp busy=0 hilo=%h", busy, {hi, lo}, {m_hi, m_lo});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_divzero_mthi();
        test_reset_mid();
        test_flush_run();
        test_none();
        test_random();
        test_madd();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
